// File: rtl/xfifo_port.sv
// Memory-mapped bridge between a controller data bus and a pair of streaming FIFOs.
// TX is filled by controller writes and drained by the stream; RX is the reverse.
module xfifo_port #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] tx_mem_r [DEPTH];
    logic [DATA_W-1:0] rx_mem_r [DEPTH];
    logic [PTR_W-1:0]  tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
    logic [CNT_W-1:0]  tx_count_r, rx_count_r;
    logic              tx_overflow_r, rx_underflow_r;

    logic rd_s, wr_s;
    logic tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic tx_push_s, tx_pop_s, tx_flush_s, tx_ovf_set_s;
    logic rx_push_s, rx_pop_s, rx_flush_s, rx_unf_set_s;
    logic [1:0]        err_clr_s;
    logic [7:0]        tx_cnt8_s, rx_cnt8_s;
    logic [DATA_W-1:0] rx_head_s;

    assign rd_s = sel & ~we;
    assign wr_s = sel & we;

    assign tx_full_s  = (tx_count_r == CNT_W'(DEPTH));
    assign tx_empty_s = (tx_count_r == {CNT_W{1'b0}});
    assign rx_full_s  = (rx_count_r == CNT_W'(DEPTH));
    assign rx_empty_s = (rx_count_r == {CNT_W{1'b0}});

    // Full/empty are judged on pre-edge counts, so a same-cycle pop never frees room for a push.
    assign tx_push_s    = wr_s & (addr == 2'd0) & ~tx_full_s;
    assign tx_ovf_set_s = wr_s & (addr == 2'd0) & tx_full_s;
    assign tx_pop_s     = tx_valid & tx_ready;
    assign tx_flush_s   = wr_s & (addr == 2'd1) & data_in[0];
    assign rx_push_s    = rx_valid & ~rx_full_s;
    assign rx_pop_s     = rd_s & (addr == 2'd0) & ~rx_empty_s;
    assign rx_unf_set_s = rd_s & (addr == 2'd0) & rx_empty_s;
    assign rx_flush_s   = wr_s & (addr == 2'd1) & data_in[1];
    assign err_clr_s    = (wr_s & (addr == 2'd3)) ? data_in[1:0] : 2'b00;

    assign tx_cnt8_s = 8'(tx_count_r);
    assign rx_cnt8_s = 8'(rx_count_r);

    assign tx_valid  = ~tx_empty_s;
    assign tx_data   = tx_empty_s ? {DATA_W{1'b0}} : tx_mem_r[tx_rd_ptr_r];
    assign rx_ready  = ~rx_full_s;
    assign rx_head_s = rx_empty_s ? {DATA_W{1'b0}} : rx_mem_r[rx_rd_ptr_r];

    // Controller read mux; anything not a read returns zero.
    always_comb begin
        data_out = {DATA_W{1'b0}};
        if (rd_s) begin
            case (addr)
                2'd0:    data_out = rx_head_s;
                2'd1:    data_out = DATA_W'({8'h00, rx_cnt8_s, tx_cnt8_s, 4'h0,
                                             rx_empty_s, rx_full_s, tx_empty_s, tx_full_s});
                2'd2:    data_out = rx_head_s;
                2'd3:    data_out = DATA_W'({rx_underflow_r, tx_overflow_r});
                default: data_out = {DATA_W{1'b0}};
            endcase
        end else begin
            data_out = {DATA_W{1'b0}};
        end
    end

    // FIFO storage; deliberately not reset, validity is carried by the counts.
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= data_in;
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_data;
    end

    // TX pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst || tx_flush_s) begin
            tx_wr_ptr_r <= {PTR_W{1'b0}};
            tx_rd_ptr_r <= {PTR_W{1'b0}};
            tx_count_r  <= {CNT_W{1'b0}};
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_W'(1);
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_W'(1);
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + CNT_W'(1);
                2'b01:   tx_count_r <= tx_count_r - CNT_W'(1);
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // RX pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst || rx_flush_s) begin
            rx_wr_ptr_r <= {PTR_W{1'b0}};
            rx_rd_ptr_r <= {PTR_W{1'b0}};
            rx_count_r  <= {CNT_W{1'b0}};
        end else begin
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_W'(1);
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_W'(1);
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + CNT_W'(1);
                2'b01:   rx_count_r <= rx_count_r - CNT_W'(1);
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // Sticky error flags; a write-1-to-clear beats a same-cycle set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_overflow_r  <= 1'b0;
            rx_underflow_r <= 1'b0;
        end else begin
            tx_overflow_r  <= err_clr_s[0] ? 1'b0 : (tx_overflow_r | tx_ovf_set_s);
            rx_underflow_r <= err_clr_s[1] ? 1'b0 : (rx_underflow_r | rx_unf_set_s);
        end
    end

endmodule

// File: tb/tb_xfifo_port.sv
// Scoreboard bench for xfifo_port: stimulus queues expected read/stream words,
// a negedge monitor pops and compares whenever a read or TX handshake is presented.
module tb_xfifo_port;

    logic        clk = 1'b0;
    logic        rst, sel, we, tx_ready, rx_valid;
    logic [1:0]  addr;
    logic [31:0] data_in, data_out, tx_data, rx_data;
    logic        tx_valid, rx_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    logic [31:0] tx_q[$];

    xfifo_port #(.DATA_W(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected STATUS word built from occupancy counts of an 8-deep FIFO pair.
    function automatic logic [31:0] st(input int rxc, input int txc);
        logic [7:0] r8, t8;
        r8 = 8'(rxc);
        t8 = 8'(txc);
        return {8'h00, r8, t8, 4'h0, (rxc == 0), (rxc == 8), (txc == 0), (txc == 8)};
    endfunction

    // Monitor: compare controller reads and TX handshakes against the scoreboard.
    always @(negedge clk) begin
        if (sel === 1'b1 && we === 1'b0) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got 0x%08h expected no read", data_out);
            end else begin
                chk(rd_name_q.pop_front(), data_out, rd_q.pop_front());
            end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (tx_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_unexpected: got 0x%08h expected no handshake", tx_data);
            end else begin
                chk("tx_data", tx_data, tx_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        sel = 1'b1; we = 1'b0; addr = a;
        tick();
        sel = 1'b0;
    endtask

    task automatic stream(input logic [31:0] d);
        rx_valid = 1'b1; rx_data = d;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'h0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'h0;

        // 1. reset
        tick(); tick();
        rst = 1'b1;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        chk("rst_tx_data", tx_data, 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        rd("rst_status", 2'd1, 32'h0000000A);
        rd("rst_err", 2'd3, 32'h0);

        // 2. TX fill, overflow, drain
        for (int i = 1; i <= 8; i++) begin
            wr(2'd0, 32'(i * 'h11));
            tx_q.push_back(32'(i * 'h11));
        end
        rd("tx_full_status", 2'd1, st(0, 8));
        chk("tx_full_status_const", st(0, 8), 32'h00000809);
        wr(2'd0, 32'h99);
        rd("tx_ovf_err", 2'd3, 32'h1);
        tx_ready = 1'b1;
        repeat (8) tick();
        chk("tx_drained_valid", 32'(tx_valid), 32'h0);
        chk("tx_drained_q", 32'(tx_q.size()), 32'h0);
        tx_ready = 1'b0;
        wr(2'd3, 32'h3);
        rd("err_cleared", 2'd3, 32'h0);

        // 3. RX path, peek, underflow, W1C
        stream(32'hA5A5A5A5);
        stream(32'h5A5A5A5A);
        rd("peek1", 2'd2, 32'hA5A5A5A5);
        rd("peek2", 2'd2, 32'hA5A5A5A5);
        rd("rx2_status", 2'd1, st(2, 0));
        rd("rx_data1", 2'd0, 32'hA5A5A5A5);
        rd("rx_data2", 2'd0, 32'h5A5A5A5A);
        rd("rx_underflow_data", 2'd0, 32'h0);
        rd("peek_empty", 2'd2, 32'h0);
        rd("rx_unf_err", 2'd3, 32'h2);
        wr(2'd3, 32'h2);
        rd("rx_unf_clr", 2'd3, 32'h0);

        // 4. RX concurrent push/pop across pointer wrap
        for (int k = 0; k < 4; k++) stream(32'h100 + 32'(k));
        for (int j = 0; j < 20; j++) begin
            rd_q.push_back(32'h100 + 32'(j));
            rd_name_q.push_back("rx_conc");
            sel = 1'b1; we = 1'b0; addr = 2'd0;
            rx_valid = 1'b1; rx_data = 32'h100 + 32'(j + 4);
            tick();
        end
        sel = 1'b0; rx_valid = 1'b0;
        rd("rx_conc_status", 2'd1, st(4, 0));
        for (int k = 20; k < 24; k++) rd("rx_conc_tail", 2'd0, 32'h100 + 32'(k));

        // 4b. TX push+pop in the same cycle while full
        for (int k = 0; k < 8; k++) begin
            wr(2'd0, 32'h200 + 32'(k));
            tx_q.push_back(32'h200 + 32'(k));
        end
        tx_ready = 1'b1;
        wr(2'd0, 32'hDEAD);
        repeat (7) tick();
        chk("tx_fullpop_valid", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;
        rd("tx_fullpop_err", 2'd3, 32'h1);
        wr(2'd3, 32'h1);

        // 5. flush both FIFOs with an RX word offered
        for (int k = 0; k < 3; k++) wr(2'd0, 32'h300 + 32'(k));
        for (int k = 0; k < 5; k++) stream(32'h400 + 32'(k));
        rd("pre_flush_status", 2'd1, st(5, 3));
        rx_valid = 1'b1; rx_data = 32'hBAD0BAD0;
        wr(2'd1, 32'h3);
        rx_valid = 1'b0;
        rd("post_flush_status", 2'd1, 32'h0000000A);
        chk("post_flush_tx_valid", 32'(tx_valid), 32'h0);
        rd("flush_lost_word", 2'd0, 32'h0);
        rd("flush_unf_err", 2'd3, 32'h2);
        wr(2'd3, 32'h3);

        // 6. reset while TX holds words and the consumer is ready
        for (int k = 0; k < 4; k++) wr(2'd0, 32'h61 + 32'(k));
        tx_q.push_back(32'h61);
        rst = 1'b0; tx_ready = 1'b1;
        tick();
        chk("midrst_tx_valid", 32'(tx_valid), 32'h0);
        chk("midrst_tx_data", tx_data, 32'h0);
        rst = 1'b1;
        repeat (3) tick();
        chk("midrst_idle_valid", 32'(tx_valid), 32'h0);
        wr(2'd0, 32'h77);
        tx_q.push_back(32'h77);
        repeat (2) tick();
        tx_ready = 1'b0;
        rd("midrst_status", 2'd1, 32'h0000000A);

        tick();
        chk("tx_q_empty", 32'(tx_q.size()), 32'h0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
